// File: rtl/iter_shifter_pkg.sv
// Shared constants for the iterative shifter: operation codes and FSM encoding.
package iter_shifter_pkg;

  // Operation codes carried on in_type; codes 5..7 are treated as sll.
  localparam logic [2:0] SH_SRL = 3'd0;
  localparam logic [2:0] SH_SLL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One partial shift of 0..STEP positions in any of the supported modes.
// Right-going modes shift a double-width word {fill, op} right and keep the
// low half; left-going modes shift {op, fill} left and keep the high half.
// The fill half is zeros, the replicated sign bit, or the operand itself
// for rotates.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int AW = $clog2(STEP) + 1
) (
  input  logic [XLEN-1:0] op_i,
  input  logic [AW-1:0]   amt_i,
  input  logic [2:0]      mode_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] res_o
);

  logic [2*XLEN-1:0] wide;
  logic [XLEN-1:0]   fill;

  // Select the fill half for the mode, then take the relevant half of the shifted word.
  always_comb begin
    fill  = '0;
    wide  = '0;
    res_o = op_i;
    case (mode_i)
      SH_SRL, SH_SRA, SH_ROR: begin
        if (mode_i == SH_SRA) begin
          fill = {XLEN{sign_i}};
        end else if (mode_i == SH_ROR) begin
          fill = op_i;
        end
        wide  = {fill, op_i} >> amt_i;
        res_o = wide[XLEN-1:0];
      end
      default: begin
        // sll, rol and the unused codes 5..7 (which behave as sll)
        if (mode_i == SH_ROL) begin
          fill = op_i;
        end
        wide  = {op_i, fill} << amt_i;
        res_o = wide[2*XLEN-1:XLEN];
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts/rotates an XLEN-bit operand by up to XLEN-1
// positions, at most STEP bits per cycle, with valid/ready on both sides.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high; accept latches operand, amount, type, sign
// ST_SHIFT | rem counts down by min(STEP, rem) per cycle; rem==0 -> DONE
// ST_DONE  | out_valid high, out_r held; out_ready returns to IDLE
//
// flush forces IDLE from any state; working registers may keep stale data.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [SHW-1:0]  in_shamt,
  input  logic [2:0]      in_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_r
);

  localparam int AW = $clog2(STEP) + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [2:0]      type_q, type_d;
  logic            sign_q, sign_d;

  logic [AW-1:0]   step_amt;
  logic [XLEN-1:0] step_res;

  // This cycle's shift: whatever remains, capped at STEP.
  assign step_amt = (rem_q < SHW'(STEP)) ? rem_q[AW-1:0] : AW'(STEP);

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .op_i   (work_q),
    .amt_i  (step_amt),
    .mode_i (type_q),
    .sign_i (sign_q),
    .res_o  (step_res)
  );

  // Next-state and datapath update; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    type_d  = type_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_a;
          rem_d   = in_shamt;
          type_d  = in_type;
          sign_d  = in_a[XLEN-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          work_d = step_res;
          rem_d  = rem_q - SHW'(step_amt);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // State and working registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      type_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_r     = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter across several XLEN/STEP configurations.
module tb_iter_shifter;

  localparam int NCFG = 7;
  localparam int CFG_XLEN [NCFG] = '{32, 32, 32, 32, 16, 16, 16};
  localparam int CFG_STEP [NCFG] = '{1, 4, 2, 8, 1, 2, 8};

  typedef struct {
    int          cfg;
    logic [31:0] val;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_a = '0;
  logic [4:0]      in_shamt = '0;
  logic [2:0]      in_type = '0;
  logic [NCFG-1:0] in_valid_v = '0;
  logic [NCFG-1:0] probe_idle = '0;
  logic [NCFG-1:0] in_ready_v;
  logic [NCFG-1:0] out_valid_v;
  logic [31:0]     out_r_v [NCFG];

  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int XL = CFG_XLEN[g];
    localparam int SW = $clog2(XL);
    logic [XL-1:0] r_w;
    iter_shifter #(
      .XLEN (XL),
      .STEP (CFG_STEP[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_a      (in_a[XL-1:0]),
      .in_shamt  (in_shamt[SW-1:0]),
      .in_type   (in_type),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_r     (r_w)
    );
    assign out_r_v[g] = 32'(r_w);
  end

  // Reference: single-shot operation on a w-bit value using 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input int w, input logic [31:0] a,
                                            input int sh, input logic [2:0] ty);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, a} & m;
    case (ty)
      3'd0:    r = x >> sh;
      3'd2:    r = (x[w-1] ? (x | ~m) : x) >> sh;
      3'd3:    r = (x << sh) | (x >> (w - sh));
      3'd4:    r = (x >> sh) | (x << (w - sh));
      default: r = x << sh;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Monitor: samples on the falling edge, compares against the scoreboard head.
  initial begin : mon
    exp_t e;
    bit   seen_valid;
    bit   match;
    seen_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_valid = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
          check(in_ready_v[k] == 1'b1, "reset_in_ready", 32'(in_ready_v[k]), 32'd1);
          check(out_valid_v[k] == 1'b0, "reset_out_valid", 32'(out_valid_v[k]), 32'd0);
          check(out_r_v[k] == 32'd0, "reset_out_r", out_r_v[k], 32'd0);
        end
      end else begin
        for (int k = 0; k < NCFG; k++) begin
          if (probe_idle[k]) begin
            check(in_ready_v[k] == 1'b1, "flush_in_ready", 32'(in_ready_v[k]), 32'd1);
            check(out_valid_v[k] == 1'b0, "flush_out_valid", 32'(out_valid_v[k]), 32'd0);
          end
          if (out_valid_v[k]) begin
            match = 1'b0;
            if (exp_q.size() != 0) match = (exp_q[0].cfg == k);
            check(match, "out_valid_expected_cfg", 32'(k), 32'(k));
            if (match) begin
              e = exp_q[0];
              if (!seen_valid) begin
                check((cyc - e.acc) == e.lat, {e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                seen_valid = 1'b1;
              end
              check(out_r_v[k] == e.val, {e.name, "_result"}, out_r_v[k], e.val);
              check(in_ready_v[k] == 1'b0, {e.name, "_in_ready_low"}, 32'(in_ready_v[k]), 32'd0);
              if (out_ready) begin
                void'(exp_q.pop_front());
                seen_valid = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request to configuration k and return the accept cycle.
  task automatic issue(input int k, input logic [2:0] ty, input logic [31:0] a,
                       input int sh, output int acc);
    int n;
    n          = 0;
    in_type    = ty;
    in_a       = a;
    in_shamt   = 5'(sh);
    in_valid_v[k] = 1'b1;
    while (!in_ready_v[k]) begin
      tick();
      n++;
      if (n > 200) begin
        $display("FAIL wait_in_ready cfg%0d: in_ready stayed 0, required 1", k);
        $fatal(1, "in_ready timeout");
      end
    end
    tick();
    acc = cyc;
    in_valid_v[k] = 1'b0;
  endtask

  task automatic run_req(input int k, input logic [2:0] ty, input logic [31:0] a,
                         input int sh, input logic [31:0] exp_val, input int hold,
                         input bit junk, input string name);
    int   acc, n;
    exp_t e;
    issue(k, ty, a, sh, acc);
    e.cfg  = k;
    e.val  = exp_val;
    e.acc  = acc;
    e.lat  = (sh + CFG_STEP[k] - 1) / CFG_STEP[k] + 1;
    e.name = name;
    exp_q.push_back(e);
    if (junk) begin
      in_valid_v[k] = 1'b1;
      in_a     = $urandom;
      in_shamt = 5'($urandom);
      in_type  = 3'($urandom);
    end
    n = 0;
    while (!out_valid_v[k]) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL %s wait_out_valid cfg%0d: out_valid stayed 0, required 1", name, k);
        $fatal(1, "out_valid timeout");
      end
    end
    repeat (hold) tick();
    in_valid_v[k] = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : drv
    int          acc;
    logic [2:0]  ty;
    logic [31:0] a;
    int          sh;

    #23 rst_n = 1'b1;
    tick();

    run_req(0, 3'd2, 32'h8000_0000, 4, 32'hF800_0000, 0, 1'b0, "sra_step1");
    run_req(1, 3'd4, 32'h1234_5678, 8, 32'h7812_3456, 0, 1'b0, "ror_step4");
    run_req(1, 3'd3, 32'h8000_0001, 1, 32'h0000_0003, 0, 1'b0, "rol_step4");
    run_req(0, 3'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 1'b0, "srl_shamt0");
    run_req(0, 3'd7, 32'h0000_0001, 31, 32'h8000_0000, 0, 1'b0, "type7_sll");

    // Backpressure with a competing request held on in_valid.
    run_req(1, 3'd2, 32'h9ABC_DEF0, 12, 32'hFFF9_ABCD, 10, 1'b1, "backpressure");

    // Flush during the third SHIFT cycle: no result may appear.
    issue(0, 3'd0, 32'hFFFF_FFFF, 20, acc);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    probe_idle[0] = 1'b1;
    tick();
    probe_idle[0] = 1'b0;
    repeat (25) tick();
    run_req(0, 3'd1, 32'h0000_0001, 3, 32'h0000_0008, 0, 1'b0, "after_flush");

    // Asynchronous reset mid-SHIFT, asserted and released between edges.
    issue(0, 3'd1, 32'h0000_0001, 20, acc);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    repeat (25) tick();
    run_req(0, 3'd4, 32'h0000_00F1, 4, 32'h1000_000F, 0, 1'b0, "after_reset");

    // Random sweep over every configuration; first two requests hit the shamt bounds.
    for (int k = 0; k < NCFG; k++) begin
      for (int i = 0; i < 30; i++) begin
        ty = 3'($urandom_range(0, 7));
        a  = $urandom;
        sh = $urandom_range(0, CFG_XLEN[k] - 1);
        if (i == 0) sh = 0;
        if (i == 1) sh = CFG_XLEN[k] - 1;
        run_req(k, ty, a, sh, ref_model(CFG_XLEN[k], a, sh, ty),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
      end
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised successor to the single-cycle barrel shifter.
- Shifts an XLEN-bit operand by up to XLEN-1 positions, at most STEP bits per cycle.
- Supports logical shifts, arithmetic right shift and both rotates.
- Sits beside the ALU for area-constrained cores (RV16I variant, low-area RV32I); uses valid/ready on both sides so the pipeline can stall on it.

Parameters:
- XLEN, 32: operand/result width. Power of 2, at least 8.
- STEP, 1: maximum bits shifted per cycle. Power of 2, 1..XLEN/2.
- SHW (localparam), $clog2(XLEN): shift-amount width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns block to IDLE.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_a  input  XLEN  operand.
- in_shamt  input  SHW  shift amount, unsigned.
- in_type  input  3  operation: 0 srl, 1 sll, 2 sra, 3 rol, 4 ror; 5..7 behave as sll.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- out_r  output  XLEN  result; held stable while out_valid is high.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_r=0; internal remaining-count and type registers = 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a into the working register, latch in_shamt as rem, latch in_type, and latch sign=in_a[XLEN-1]. Go to SHIFT.
  - SHIFT: if rem==0, go to DONE. Otherwise shift the working register by s=min(STEP,rem) in the latched mode and set rem=rem-s.
  - DONE: out_valid=1 and out_r=working register. On out_ready go to IDLE; otherwise hold. in_ready=0.
- Latency: out_valid rises ceil(shamt/STEP)+1 cycles after the accept edge. shamt=0 gives 1 cycle, with out_r equal to in_a.
- Throughput: one request in flight. The earliest next accept is the cycle after the out_ready handshake. There is no same-cycle out/in overlap.
- Mode arithmetic per step:
  - srl: zero fill from MSB.
  - sll: zero fill at LSB.
  - sra: fill with the latched sign bit, so the result equals $signed(a)>>>shamt.
  - rol/ror: bits wrap around; result equals the full rotate by shamt mod XLEN.
- Final result must match the single-shot operation bit-exactly for every shamt in 0..XLEN-1.
- flush:
  - Has priority over every transition except reset.
  - Next state is IDLE; out_valid drops the next cycle. A flush in DONE discards the result.
  - Working registers may keep stale data; out_r is don't-care outside DONE.
- Reset mid-operation: immediate return to reset values, with no partial result visible.
- in_valid while not IDLE is ignored (in_ready=0); the request must be held by the producer.
- Inputs are sampled only at accept; later changes to in_a, in_shamt or in_type have no effect on the operation in flight.

Decomposition:
- Package iter_shifter_pkg:
  - Mode constants SH_SRL=3'd0, SH_SLL=3'd1, SH_SRA=3'd2, SH_ROL=3'd3, SH_ROR=3'd4.
  - State encoding ST_IDLE, ST_SHIFT, ST_DONE (2 bits).
- Sub-module shift_step:
  - Combinational, parameters XLEN and STEP.
  - Inputs: operand, amount (0..STEP), mode, sign fill bit. Output: shifted value.
  - Instantiated once in the SHIFT datapath.

Test Plan:
- XLEN=32, STEP=1. sra with a=0x80000000, shamt=4 → out_r=0xF8000000, out_valid exactly 5 cycles after the accept edge.
- XLEN=32, STEP=4. ror with a=0x12345678, shamt=8 → out_r=0x78123456, latency 3 cycles. rol with a=0x80000001, shamt=1 → 0x00000003, latency 2 cycles.
- shamt=0 with srl, a=0xDEADBEEF → out_r=0xDEADBEEF after 1 cycle. Type 7 with a=0x1, shamt=31 → 0x80000000, behaving as sll.
- Backpressure: out_ready held low 10 cycles in DONE → out_valid and out_r stay stable, in_ready stays 0, and a new in_valid is ignored until the handshake completes.
- flush asserted in the 3rd SHIFT cycle of srl a=0xFFFFFFFF, shamt=20 → IDLE next cycle, no out_valid pulse. The next request, sll a=0x1, shamt=3, returns 0x8.
- rst_n pulsed low asynchronously, mid-SHIFT and between clock edges → outputs go to reset values immediately. Random sweep over XLEN∈{16,32} and STEP∈{1,2,8} with all types and shamts matches a reference model.
